// File: rtl/adc_capture_sequencer_pkg.sv
// Shared types and constants for the ADC capture sequencer: state encoding,
// GPIO control bit positions and default counter widths.
package adc_capture_sequencer_pkg;

  localparam int ADC_SEQ_CNT_W = 32;
  localparam int ADC_SEQ_LEN_W = 16;
  localparam int ADC_SEQ_REP_W = 16;

  // Bit positions of the sequencer controls within the rfsoc_ctrl GPIO word
  localparam int adc_seq_arm       = 0;
  localparam int adc_seq_abort     = 1;
  localparam int adc_seq_retrigger = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_CAPTURE,
    ST_GAP,
    ST_READOUT,
    ST_FLUSH
  } adc_seq_state_t;

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Command, config, FIFO-status and gating signals between the GPIO decode /
// adc_driver side (master) and the capture sequencer (slave).
interface adc_capture_sequencer_if
  import adc_capture_sequencer_pkg::*;
#(
  parameter int CNT_W = ADC_SEQ_CNT_W,
  parameter int LEN_W = ADC_SEQ_LEN_W,
  parameter int REP_W = ADC_SEQ_REP_W
) ();

  logic             arm;
  logic             abort;
  logic             trigger;
  logic [CNT_W-1:0] cfg_delay;
  logic [LEN_W-1:0] cfg_length;
  logic [REP_W-1:0] cfg_repeats;
  logic             cfg_retrigger;
  logic             s_valid;
  logic             fifo_full;
  logic             fifo_empty;

  logic             capture_en;
  logic             readout_en;
  logic             flush;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             cfg_err;
  logic [REP_W-1:0] window_idx;

  modport master (
    output arm, abort, trigger, cfg_delay, cfg_length, cfg_repeats, cfg_retrigger,
    output s_valid, fifo_full, fifo_empty,
    input  capture_en, readout_en, flush, busy, done, overflow, cfg_err, window_idx
  );

  modport slave (
    input  arm, abort, trigger, cfg_delay, cfg_length, cfg_repeats, cfg_retrigger,
    input  s_valid, fifo_full, fifo_empty,
    output capture_en, readout_en, flush, busy, done, overflow, cfg_err, window_idx
  );

endinterface

// File: rtl/adc_seq_counter.sv
// Loadable down-counter with zero flag; used for the trigger delay and the
// inter-window gap. Holds at zero rather than wrapping.
module adc_seq_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_capture_sequencer.sv
// Arms on GPIO command, waits for trigger edges and gates fixed-length ADC
// windows into the storage FIFO, then enables PS readout or flushes on abort.
module adc_capture_sequencer
  import adc_capture_sequencer_pkg::*;
#(
  parameter int CNT_W = ADC_SEQ_CNT_W,
  parameter int LEN_W = ADC_SEQ_LEN_W,
  parameter int REP_W = ADC_SEQ_REP_W
) (
  input logic                    clk,
  input logic                    rst,
  adc_capture_sequencer_if.slave bus
);

  adc_seq_state_t   state_q, state_d;
  logic             trig_q;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_last_q, rep_last_d;
  logic             retrig_q, retrig_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [REP_W-1:0] window_idx_q, window_idx_d;
  logic             overflow_q, overflow_d;
  logic             cfg_err_q, cfg_err_d;
  logic             done_q, done_d;

  logic             trig_rise;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign trig_rise = bus.trigger & ~trig_q;
  assign cnt_dec   = (state_q == ST_DELAY) || (state_q == ST_GAP);

  adc_seq_counter #(.W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    len_d        = len_q;
    rep_last_d   = rep_last_q;
    retrig_d     = retrig_q;
    word_cnt_d   = word_cnt_q;
    window_idx_d = window_idx_q;
    overflow_d   = overflow_q;
    cfg_err_d    = cfg_err_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    // The counter is loaded with delay-1 so that capture starts delay cycles after the edge cycle
    cnt_load_val = delay_q - CNT_W'(1);

    if (bus.abort && ((state_q != ST_IDLE) || !bus.fifo_empty)) begin
      state_d    = ST_FLUSH;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arm && !bus.abort) begin
            if (bus.cfg_length == '0) begin
              cfg_err_d = 1'b1;
            end else begin
              state_d      = ST_ARMED;
              delay_d      = bus.cfg_delay;
              len_d        = bus.cfg_length;
              rep_last_d   = (bus.cfg_repeats == '0) ? '0 : bus.cfg_repeats - REP_W'(1);
              retrig_d     = bus.cfg_retrigger;
              overflow_d   = 1'b0;
              cfg_err_d    = 1'b0;
              window_idx_d = '0;
              word_cnt_d   = '0;
            end
          end
        end
        ST_ARMED: begin
          if (trig_rise) begin
            if (delay_q == '0) begin
              state_d = ST_CAPTURE;
            end else begin
              state_d  = ST_DELAY;
              cnt_load = 1'b1;
            end
          end
        end
        ST_DELAY, ST_GAP: begin
          if (cnt_zero) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Words hitting a full FIFO are dropped but still counted, keeping window time fixed
          if (bus.s_valid) begin
            if (bus.fifo_full) begin
              overflow_d = 1'b1;
            end
            if (word_cnt_q == (len_q - LEN_W'(1))) begin
              word_cnt_d = '0;
              if (window_idx_q == rep_last_q) begin
                state_d = ST_READOUT;
              end else begin
                window_idx_d = window_idx_q + REP_W'(1);
                if (retrig_q) begin
                  state_d = ST_ARMED;
                end else if (delay_q == '0) begin
                  state_d = ST_CAPTURE;
                end else begin
                  state_d  = ST_GAP;
                  cnt_load = 1'b1;
                end
              end
            end else begin
              word_cnt_d = word_cnt_q + LEN_W'(1);
            end
          end
        end
        ST_READOUT: begin
          if (bus.fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (bus.fifo_empty) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trig_q       <= 1'b0;
      delay_q      <= '0;
      len_q        <= '0;
      rep_last_q   <= '0;
      retrig_q     <= 1'b0;
      word_cnt_q   <= '0;
      window_idx_q <= '0;
      overflow_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= bus.trigger;
      delay_q      <= delay_d;
      len_q        <= len_d;
      rep_last_q   <= rep_last_d;
      retrig_q     <= retrig_d;
      word_cnt_q   <= word_cnt_d;
      window_idx_q <= window_idx_d;
      overflow_q   <= overflow_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
    end
  end

  assign bus.capture_en = (state_q == ST_CAPTURE);
  assign bus.readout_en = (state_q == ST_READOUT);
  assign bus.flush      = (state_q == ST_FLUSH);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.window_idx = window_idx_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Scoreboard bench for adc_capture_sequencer: expected capture cycles, readout
// starts and done pulses are queued when a trigger is driven and popped by a monitor.
module tb_adc_capture_sequencer;
  import adc_capture_sequencer_pkg::*;

  typedef struct {
    int cyc;
    int idx;
  } cap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_capture_sequencer_if bus ();

  adc_capture_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   words = 0;
  int   flush_cycles = 0;
  int   fifo_cnt = 0;
  bit   valid_mode = 1'b0;
  int   valid_phase = 0;
  bit   ro_prev = 1'b0;
  cap_t mon_e;
  int   mon_i;
  cap_t cap_q[$];
  int   ro_q[$];
  int   done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit valid_at(input int c);
    if (valid_mode) return ((c - valid_phase) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.s_valid = valid_at(cyc);
  endtask

  // Monitor plus a simple FIFO occupancy model; one word leaves per readout/flush cycle
  initial begin
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.capture_en) begin
        if (cap_q.size() == 0) begin
          check_eq("cap_expected", cap_q.size(), 1);
        end else begin
          mon_e = cap_q.pop_front();
          check_eq("cap_cyc", cyc, mon_e.cyc);
          check_eq("cap_widx", bus.window_idx, mon_e.idx);
        end
        if (bus.s_valid && !bus.fifo_full) begin
          words++;
          fifo_cnt++;
        end
      end
      if (bus.readout_en && !ro_prev) begin
        if (ro_q.size() == 0) check_eq("ro_expected", ro_q.size(), 1);
        else begin
          mon_i = ro_q.pop_front();
          check_eq("ro_start", cyc, mon_i);
        end
      end
      ro_prev = bus.readout_en;
      if (bus.done) begin
        if (done_q.size() == 0) check_eq("done_expected", done_q.size(), 1);
        else begin
          mon_i = done_q.pop_front();
          check_eq("done_cyc", cyc, mon_i);
        end
      end
      if (bus.flush) flush_cycles++;
      if ((bus.readout_en || bus.flush) && (fifo_cnt > 0)) fifo_cnt--;
      bus.fifo_empty = (fifo_cnt == 0);
    end
  end

  task automatic push_window(input int start, input int len, input int idx, output int last);
    int c;
    int n;
    c = start;
    n = 0;
    while (n < len) begin
      cap_q.push_back('{cyc: c, idx: idx});
      if (valid_at(c)) n++;
      c++;
    end
    last = c - 1;
  endtask

  task automatic arm_cfg(input int delay, input int len, input int rep, input bit retrig);
    words = 0;
    flush_cycles = 0;
    bus.cfg_delay = delay;
    bus.cfg_length = len[15:0];
    bus.cfg_repeats = rep[15:0];
    bus.cfg_retrigger = retrig;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.busy && (n < limit)) begin
      tick();
      n++;
    end
    check_eq("idle_reached", bus.busy, 0);
  endtask

  task automatic finish_test(input string name, input int exp_words);
    repeat (3) tick();
    check_eq("cap_left", cap_q.size(), 0);
    check_eq("ro_left", ro_q.size(), 0);
    check_eq("done_left", done_q.size(), 0);
    check_eq("words", words, exp_words);
    $display("scenario %s finished at cycle %0d words=%0d", name, cyc, words);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_capture_en"}, bus.capture_en, 0);
    check_eq({tag, "_readout_en"}, bus.readout_en, 0);
    check_eq({tag, "_flush"}, bus.flush, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_overflow"}, bus.overflow, 0);
    check_eq({tag, "_cfg_err"}, bus.cfg_err, 0);
    check_eq({tag, "_window_idx"}, bus.window_idx, 0);
  endtask

  // Continuous-gap sequence; cfg is scrambled after the edge to prove it is shadowed
  task automatic run_basic(input string name, input int delay, input int len, input int rep,
                           input bit alt);
    int t;
    int start;
    int last;
    arm_cfg(delay, len, rep, 1'b0);
    bus.trigger = 1'b1;
    t = cyc;
    valid_mode = alt;
    valid_phase = t + 1 + delay;
    start = t + 1 + delay;
    last = start;
    for (int w = 0; w < rep; w++) begin
      push_window(start, len, w, last);
      start = last + 1 + delay;
    end
    ro_q.push_back(last + 1);
    done_q.push_back(last + 1 + len * rep);
    bus.cfg_delay = 9;
    bus.cfg_length = 16'd1;
    bus.cfg_repeats = 16'd5;
    bus.cfg_retrigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    wait_idle(300);
    finish_test(name, len * rep);
    valid_mode = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int t;
    int last;
    rst = 1'b1;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.trigger = 1'b0;
    bus.cfg_delay = '0;
    bus.cfg_length = '0;
    bus.cfg_repeats = '0;
    bus.cfg_retrigger = 1'b0;
    bus.s_valid = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_outputs_zero("reset");

    run_basic("single_window", 3, 4, 1, 1'b0);
    check_eq("single_widx", bus.window_idx, 0);
    run_basic("three_windows_gap", 2, 2, 3, 1'b0);
    check_eq("three_widx_last", bus.window_idx, 2);
    run_basic("sparse_valid", 0, 4, 1, 1'b1);

    // Full FIFO during capture: overflow set, window length unchanged, nothing stored
    arm_cfg(0, 3, 1, 1'b0);
    bus.fifo_full = 1'b1;
    bus.trigger = 1'b1;
    t = cyc;
    push_window(t + 1, 3, 0, last);
    ro_q.push_back(last + 1);
    done_q.push_back(last + 2);
    tick();
    bus.trigger = 1'b0;
    wait_idle(100);
    bus.fifo_full = 1'b0;
    finish_test("overflow", 0);
    check_eq("overflow_set", bus.overflow, 1);
    arm_cfg(0, 2, 1, 1'b0);
    check_eq("overflow_cleared", bus.overflow, 0);
    check_eq("rearm_busy", bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_idle(50);
    finish_test("abort_armed", 0);
    check_eq("abort_armed_flush_cycles", flush_cycles, 1);

    // Retrigger: second window needs a fresh trigger edge
    arm_cfg(1, 2, 2, 1'b1);
    bus.trigger = 1'b1;
    t = cyc;
    push_window(t + 2, 2, 0, last);
    tick();
    bus.trigger = 1'b0;
    while (cyc < last + 2) tick();
    check_eq("retrig_waiting_armed", bus.capture_en, 0);
    bus.trigger = 1'b1;
    t = cyc;
    push_window(t + 2, 2, 1, last);
    ro_q.push_back(last + 1);
    done_q.push_back(last + 5);
    tick();
    bus.trigger = 1'b0;
    wait_idle(100);
    finish_test("retrigger", 4);

    // Abort mid-capture: three words stored, then flushed, no done pulse
    arm_cfg(0, 8, 1, 1'b0);
    bus.trigger = 1'b1;
    t = cyc;
    for (int i = 1; i <= 3; i++) cap_q.push_back('{cyc: t + i, idx: 0});
    tick();
    bus.trigger = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_cap_off", bus.capture_en, 0);
    check_eq("abort_flush_on", bus.flush, 1);
    wait_idle(100);
    finish_test("abort_capture", 3);
    check_eq("abort_flush_cycles", flush_cycles, 3);
    check_eq("abort_fifo_drained", fifo_cnt, 0);

    // Zero length arm is rejected
    arm_cfg(2, 0, 1, 1'b0);
    check_eq("cfg_err_set", bus.cfg_err, 1);
    check_eq("cfg_err_not_busy", bus.busy, 0);
    tick();
    check_eq("cfg_err_still_idle", bus.busy, 0);

    // Reset during DELAY, then edges without arm must do nothing
    arm_cfg(5, 4, 1, 1'b0);
    check_eq("cfg_err_cleared", bus.cfg_err, 0);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    check_eq("in_delay_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    check_outputs_zero("midrun_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.trigger = 1'b1;
      tick();
      bus.trigger = 1'b0;
      tick();
    end
    check_eq("edges_ignored_busy", bus.busy, 0);
    repeat (8) tick();
    finish_test("reset_in_delay", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
